// File: rtl/common_types_pkg.sv
// rtl/common_types_pkg.sv - shared types for the instruction fetch stage
package common_types_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t inst;
    logic  branch_predict;
    word_t branch_target;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  localparam word_t INST_STRIDE = 32'd4;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular instruction queue between bus and decode
module fetch_queue
  import common_types_pkg::*;
#(
  parameter int QDEPTH = 2,
  localparam int PW = $clog2(QDEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  fetch_entry_t  push_data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output fetch_entry_t  head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  fetch_entry_t  mem_q [QDEPTH];
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  // A flush wins over a push; a pop on an empty queue is ignored.
  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && !empty_o;

  assign count_o = count_q;
  assign full_o  = (count_q == CW'(QDEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[head_q];

  // Entry storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[tail_q] <= push_data_i;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap since QDEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        tail_q <= tail_q + PW'(1);
      end
      if (do_pop) begin
        head_q <= head_q + PW'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CW'(1);
      end else if (!do_push && do_pop) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC register, instruction bus master and fetch queue
module fetch_unit
  import common_types_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_htrans,
  output logic [31:0] imem_haddr,
  input  logic        imem_hready,
  input  logic [31:0] imem_hrdata,
  output logic [31:0] bp_pc,
  input  logic        bp_taken,
  input  logic [31:0] bp_target,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        f2d_valid,
  input  logic        f2d_ready,
  output logic [31:0] f2d_pc,
  output logic [31:0] f2d_inst,
  output logic        f2d_branch_predict,
  output logic [31:0] f2d_branch_target
);

  localparam int CW = $clog2(QDEPTH) + 1;

  fetch_state_t  state_q;
  word_t         pc_q;
  word_t         tag_pc_q;
  word_t         tag_tgt_q;
  logic          tag_bp_q;
  logic          hold_q;
  logic          run_q;

  fetch_entry_t  q_head;
  fetch_entry_t  q_push_data;
  logic [CW-1:0] q_count;
  logic          q_full;
  logic          q_empty;

  logic          pop;
  logic          push;
  logic          issue;
  logic          accept;
  logic [CW:0]   used;

  // Slots committed after this cycle: queued entries plus the live data phase,
  // minus the entry decode takes now. A held address phase must stay asserted.
  assign f2d_valid = !q_empty;
  assign pop       = f2d_valid && f2d_ready;
  assign used      = {1'b0, q_count} + (CW+1)'(state_q == DATA) - (CW+1)'(pop);
  assign issue     = run_q && (state_q != DROP) && (hold_q || (used < (CW+1)'(QDEPTH)));
  assign accept    = issue && imem_hready;
  assign push      = (state_q == DATA) && imem_hready && !redirect_valid;

  assign imem_htrans = issue;
  assign imem_haddr  = pc_q;
  assign bp_pc       = pc_q;

  assign q_push_data = '{pc: tag_pc_q, inst: imem_hrdata,
                         branch_predict: tag_bp_q, branch_target: tag_tgt_q};

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (q_push_data),
    .pop_i       (pop),
    .flush_i     (redirect_valid),
    .head_o      (q_head),
    .count_o     (q_count),
    .full_o      (q_full),
    .empty_o     (q_empty)
  );

  // Invalid head shows zeros so decode never sees stale queue contents.
  assign f2d_pc             = f2d_valid ? q_head.pc             : '0;
  assign f2d_inst           = f2d_valid ? q_head.inst           : '0;
  assign f2d_branch_predict = f2d_valid ? q_head.branch_predict : 1'b0;
  assign f2d_branch_target  = f2d_valid ? q_head.branch_target  : '0;

  // A push into a full queue would mean the slot accounting above is wrong.
  assert property (@(posedge clk) disable iff (rst) !(push && q_full));

  // Bus FSM, PC advance and transfer tags; a redirect squashes everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      tag_pc_q  <= '0;
      tag_tgt_q <= '0;
      tag_bp_q  <= 1'b0;
      hold_q    <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (redirect_valid) begin
        pc_q   <= redirect_pc;
        hold_q <= 1'b0;
        // Any data phase still owed by the bus must be absorbed and discarded.
        if (accept || ((state_q != IDLE) && !imem_hready)) begin
          state_q <= DROP;
        end else begin
          state_q <= IDLE;
        end
      end else begin
        hold_q <= issue && !imem_hready;
        if (accept) begin
          tag_pc_q  <= pc_q;
          tag_bp_q  <= bp_taken;
          tag_tgt_q <= bp_target;
          pc_q      <= bp_taken ? bp_target : pc_q + INST_STRIDE;
        end
        if (state_q == DROP) begin
          if (imem_hready) begin
            state_q <= IDLE;
          end
        end else if (imem_hready) begin
          state_q <= accept ? DATA : IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;
  import common_types_pkg::*;

  logic  clk;
  logic  rst;
  logic  imem_htrans;
  word_t imem_haddr;
  logic  imem_hready;
  word_t imem_hrdata;
  word_t bp_pc;
  logic  bp_taken;
  word_t bp_target;
  logic  redirect_valid;
  word_t redirect_pc;
  logic  f2d_valid;
  logic  f2d_ready;
  word_t f2d_pc;
  word_t f2d_inst;
  logic  f2d_branch_predict;
  word_t f2d_branch_target;

  int n_cmp = 0;
  int n_err = 0;

  fetch_entry_t exp_q[$];
  fetch_entry_t pop_log[$];
  word_t        addr_log[$];
  fetch_entry_t got_e;
  fetch_entry_t exp_e;
  word_t        model_pc;
  logic         bus_load;
  word_t        bus_next;

  logic  bp_en;
  word_t bp_match;
  word_t bp_tgt;

  assign bp_taken  = bp_en && (bp_pc == bp_match);
  assign bp_target = bp_tgt;

  fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
    .clk                (clk),
    .rst                (rst),
    .imem_htrans        (imem_htrans),
    .imem_haddr         (imem_haddr),
    .imem_hready        (imem_hready),
    .imem_hrdata        (imem_hrdata),
    .bp_pc              (bp_pc),
    .bp_taken           (bp_taken),
    .bp_target          (bp_target),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .f2d_valid          (f2d_valid),
    .f2d_ready          (f2d_ready),
    .f2d_pc             (f2d_pc),
    .f2d_inst           (f2d_inst),
    .f2d_branch_predict (f2d_branch_predict),
    .f2d_branch_target  (f2d_branch_target)
  );

  function automatic word_t inst_of(word_t a);
    return {a[23:0], 8'h13};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Bus slave: drive read data for the transfer accepted at the previous edge.
  initial begin
    imem_hrdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus_load) begin
        imem_hrdata = bus_next;
        bus_load    = 1'b0;
      end
    end
  end

  // Scoreboard: own PC model, expected entries pushed on address acceptance.
  initial begin
    bus_load = 1'b0;
    bus_next = '0;
    model_pc = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        bus_load = 1'b0;
        model_pc = '0;
      end else begin
        if (f2d_valid && f2d_ready) begin
          got_e = '{pc: f2d_pc, inst: f2d_inst, branch_predict: f2d_branch_predict,
                    branch_target: f2d_branch_target};
          pop_log.push_back(got_e);
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_unexpected: got pc=%h inst=%h, required no entry", f2d_pc, f2d_inst);
          end else begin
            exp_e = exp_q.pop_front();
            if (got_e !== exp_e) begin
              n_err++;
              $display("FAIL sb_entry: got pc=%h inst=%h bp=%b tgt=%h, required pc=%h inst=%h bp=%b tgt=%h",
                       got_e.pc, got_e.inst, got_e.branch_predict, got_e.branch_target,
                       exp_e.pc, exp_e.inst, exp_e.branch_predict, exp_e.branch_target);
            end
          end
        end
        if (imem_htrans && imem_hready) begin
          addr_log.push_back(imem_haddr);
          bus_next = inst_of(imem_haddr);
          bus_load = 1'b1;
          if (!redirect_valid) begin
            n_cmp++;
            if (imem_haddr !== model_pc) begin
              n_err++;
              $display("FAIL addr_seq: got haddr=%h, required %h", imem_haddr, model_pc);
            end
            exp_q.push_back('{pc: model_pc, inst: inst_of(model_pc),
                              branch_predict: bp_en && (model_pc == bp_match), branch_target: bp_tgt});
            model_pc = (bp_en && (model_pc == bp_match)) ? bp_tgt : model_pc + 32'd4;
          end
        end
        if (redirect_valid) begin
          exp_q.delete();
          model_pc = redirect_pc;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    imem_hready    = 1'b1;
    f2d_ready      = rdy;
    bp_en          = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    pop_log.delete();
    addr_log.delete();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({imem_htrans, imem_haddr, bp_pc} !== 65'd0) begin
      n_err++;
      $display("FAIL reset_bus: got htrans=%b haddr=%h bp_pc=%h, required 0/0/0", imem_htrans, imem_haddr, bp_pc);
    end
    n_cmp++;
    if (f2d_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_valid: got %b, required 0", f2d_valid);
    end
    n_cmp++;
    if ({f2d_pc, f2d_inst, f2d_branch_predict, f2d_branch_target} !== 97'd0) begin
      n_err++;
      $display("FAIL reset_f2d_data: got pc=%h inst=%h, required zeros", f2d_pc, f2d_inst);
    end
  endtask

  task automatic test_basic;
    logic found;
    found = 1'b0;
    do_reset(1'b1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (imem_htrans) begin
        found = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!found || imem_haddr !== 32'h0) begin
      n_err++;
      $display("FAIL basic_first_addr: got htrans=%b haddr=%h, required 1/00000000", found, imem_haddr);
    end
    @(negedge clk);
    n_cmp++;
    if (imem_htrans !== 1'b1 || imem_haddr !== 32'h4 || f2d_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_cycle1: got htrans=%b haddr=%h valid=%b, required 1/00000004/0", imem_htrans, imem_haddr, f2d_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (f2d_valid !== 1'b1 || f2d_pc !== 32'h0 || f2d_inst !== 32'h13 || imem_haddr !== 32'h8) begin
      n_err++;
      $display("FAIL basic_cycle2: got valid=%b pc=%h inst=%h haddr=%h, required 1/0/00000013/00000008",
               f2d_valid, f2d_pc, f2d_inst, imem_haddr);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if (f2d_valid !== 1'b1 || f2d_pc !== 32'(4 * (i + 1)) || imem_haddr !== 32'(4 * (i + 3))) begin
        n_err++;
        $display("FAIL basic_stream: got valid=%b pc=%h haddr=%h, required 1/%h/%h",
                 f2d_valid, f2d_pc, imem_haddr, 32'(4 * (i + 1)), 32'(4 * (i + 3)));
      end
    end
  endtask

  task automatic test_backpressure;
    do_reset(1'b0);
    cyc(6);
    n_cmp++;
    if (imem_htrans !== 1'b0 || addr_log.size() != 2 || f2d_valid !== 1'b1 || f2d_pc !== 32'h0) begin
      n_err++;
      $display("FAIL bp_full: got htrans=%b issued=%0d valid=%b pc=%h, required 0/2/1/00000000",
               imem_htrans, addr_log.size(), f2d_valid, f2d_pc);
    end
    f2d_ready = 1'b1;
    cyc(4);
    n_cmp++;
    if (pop_log.size() < 2) begin
      n_err++;
      $display("FAIL bp_release_count: got %0d pops, required at least 2", pop_log.size());
    end else if (pop_log[0].pc !== 32'h0 || pop_log[1].pc !== 32'h4) begin
      n_err++;
      $display("FAIL bp_release_order: got %h,%h, required 00000000,00000004", pop_log[0].pc, pop_log[1].pc);
    end
  endtask

  task automatic test_branch;
    word_t exp_a [5];
    exp_a = '{32'h0, 32'h4, 32'h8, 32'h100, 32'h104};
    do_reset(1'b1);
    bp_en    = 1'b1;
    bp_match = 32'h8;
    bp_tgt   = 32'h100;
    cyc(10);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (addr_log.size() <= i || addr_log[i] !== exp_a[i]) begin
        n_err++;
        $display("FAIL branch_addr[%0d]: got %h, required %h", i,
                 (addr_log.size() > i) ? addr_log[i] : 32'hxxxxxxxx, exp_a[i]);
      end
    end
    n_cmp++;
    if (pop_log.size() < 4) begin
      n_err++;
      $display("FAIL branch_pops: got %0d pops, required at least 4", pop_log.size());
    end else if (pop_log[2].pc !== 32'h8 || pop_log[2].branch_predict !== 1'b1 ||
                 pop_log[2].branch_target !== 32'h100 || pop_log[3].pc !== 32'h100 ||
                 pop_log[3].branch_predict !== 1'b0) begin
      n_err++;
      $display("FAIL branch_tag: got pc=%h bp=%b tgt=%h next=%h, required 00000008/1/00000100 next 00000100",
               pop_log[2].pc, pop_log[2].branch_predict, pop_log[2].branch_target, pop_log[3].pc);
    end
    bp_en = 1'b0;
  endtask

  task automatic test_redirect;
    int n_before;
    do_reset(1'b0);
    cyc(6);
    f2d_ready = 1'b1;
    cyc(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    cyc(1);
    redirect_valid = 1'b0;
    n_before = addr_log.size();
    @(negedge clk);
    n_cmp++;
    if (f2d_valid !== 1'b0) begin
      n_err++;
      $display("FAIL redirect_flush: got valid=%b, required 0", f2d_valid);
    end
    cyc(6);
    n_cmp++;
    if (addr_log.size() <= n_before || addr_log[n_before] !== 32'h200) begin
      n_err++;
      $display("FAIL redirect_addr: got %h, required 00000200",
               (addr_log.size() > n_before) ? addr_log[n_before] : 32'hxxxxxxxx);
    end
    n_cmp++;
    if (pop_log.size() < 3 || pop_log[1].pc !== 32'h4 || pop_log[2].pc !== 32'h200) begin
      n_err++;
      $display("FAIL redirect_pops: got %0d pops (second/third pc %h/%h), required 00000004 then 00000200",
               pop_log.size(), (pop_log.size() > 1) ? pop_log[1].pc : 32'hx, (pop_log.size() > 2) ? pop_log[2].pc : 32'hx);
    end
  endtask

  task automatic test_stall;
    word_t held;
    do_reset(1'b1);
    cyc(6);
    imem_hready = 1'b0;
    @(negedge clk);
    held = imem_haddr;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++;
      if (imem_htrans !== 1'b1 || imem_haddr !== held) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: got htrans=%b haddr=%h, required 1/%h", i, imem_htrans, imem_haddr, held);
      end
    end
    @(posedge clk);
    #1;
    imem_hready = 1'b1;
    cyc(8);
    for (int i = 0; i < addr_log.size(); i++) begin
      n_cmp++;
      if (addr_log[i] !== 32'(4 * i)) begin
        n_err++;
        $display("FAIL stall_addr[%0d]: got %h, required %h", i, addr_log[i], 32'(4 * i));
      end
    end
    for (int i = 0; i < pop_log.size(); i++) begin
      n_cmp++;
      if (pop_log[i].pc !== 32'(4 * i)) begin
        n_err++;
        $display("FAIL stall_pop[%0d]: got %h, required %h", i, pop_log[i].pc, 32'(4 * i));
      end
    end
  endtask

  task automatic test_reset_mid;
    do_reset(1'b1);
    cyc(4);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({imem_htrans, imem_haddr, f2d_valid, f2d_pc, f2d_inst, f2d_branch_predict, f2d_branch_target} !== 131'd0) begin
      n_err++;
      $display("FAIL reset_mid_async: got htrans=%b haddr=%h valid=%b pc=%h, required all zero",
               imem_htrans, imem_haddr, f2d_valid, f2d_pc);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    pop_log.delete();
    addr_log.delete();
    cyc(6);
    n_cmp++;
    if (addr_log.size() == 0 || addr_log[0] !== 32'h0 || pop_log.size() == 0 ||
        pop_log[0].pc !== 32'h0 || pop_log[0].inst !== 32'h13) begin
      n_err++;
      $display("FAIL reset_mid_resume: got issued=%0d popped=%0d, required fetch restart at 00000000 with inst 00000013",
               addr_log.size(), pop_log.size());
    end
  endtask

  initial begin
    rst            = 1'b1;
    imem_hready    = 1'b1;
    f2d_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    bp_en          = 1'b0;
    bp_match       = '0;
    bp_tgt         = '0;
    test_reset;
    test_basic;
    test_backpressure;
    test_branch;
    test_redirect;
    test_stall;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the pipeline.
- Owns the PC register and issues word reads on the AHB-Lite-style instruction bus.
- Applies the branch predictor's next-PC choice.
- Buffers returned instructions in a small queue and presents them, with PC and prediction tags, to the fetch-to-decode latch.
- Handles redirects from execute (mispredict/jump) by squashing queued and in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- QDEPTH, 2, instruction queue entries (power of two, >=2).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- imem_htrans  out  1  1 = NONSEQ address phase this cycle
- imem_haddr  out  32  fetch address (word aligned)
- imem_hready  in  1  bus ready; completes address and data phase
- imem_hrdata  in  32  read data, valid in data phase when hready=1
- bp_pc  out  32  PC presented to predictor (= imem_haddr)
- bp_taken  in  1  predictor says taken for bp_pc
- bp_target  in  32  predicted target
- redirect_valid  in  1  execute redirect
- redirect_pc  in  32  corrected PC
- f2d_valid  out  1  queue head valid
- f2d_ready  in  1  decode latch en (accepts head this cycle)
- f2d_pc  out  32  head PC
- f2d_inst  out  32  head instruction
- f2d_branch_predict  out  1  head predicted taken
- f2d_branch_target  out  32  head predicted target

Behaviour:
- Reset (async, rst=1):
  - pc=RESET_PC, queue empty, state IDLE.
  - htrans=0, haddr=RESET_PC, f2d_valid=0, f2d_* data=0.
- Bus is pipelined; at most one transfer outstanding.
  - Address phase: htrans=1, haddr=pc.
  - Address is accepted when hready=1; the data phase follows and completes on the next cycle with hready=1.
- Issue rule: htrans=1 only if (queue count + outstanding) < QDEPTH, and not in DROP.
- On address acceptance, record tag {pc, bp_taken, bp_target}, then advance: pc <= bp_taken ? bp_target : pc+4 (mod 2^32 wrap).
- State machine:
  - IDLE: no outstanding transfer. Issue when there is space -> DATA.
  - DATA: data phase pending.
    - hready=1: push {tag, hrdata} into queue.
    - If space remains and the next address is also issued that cycle, stay in DATA; otherwise -> IDLE.
  - DROP: data phase pending but squashed. On hready=1, discard data -> IDLE. No new issue in DROP.
- Queue:
  - Circular buffer with head/tail pointers and a count.
  - Push and pop in the same cycle keep count unchanged.
  - Pushing when full must never happen (guaranteed by the issue rule); assert it.
- f2d outputs come from the queue head registers (no hrdata-to-decode combinational path).
- Pop when f2d_valid && f2d_ready.
- Minimum latency: first address at cycle 0 -> f2d_valid at cycle 2 with zero-wait-state bus.
- Redirect (highest priority):
  - Same cycle: queue flushed, pc <= redirect_pc, accepted address phase cancelled.
  - The following cycle issues redirect_pc.
  - A data phase in flight moves to DROP; its data is never queued.
  - A pop in the redirect cycle is still honoured (decode sees the head), but no push occurs.
- Predicted-taken target is not checked for alignment. Misaligned targets are passed through; execute will redirect.
- hready=0 in the address phase: hold htrans/haddr stable; pc is not updated.
- Reset mid-transfer: state returns to IDLE immediately, and any subsequent bus data is ignored.

Decomposition:
- common_types_pkg: word_t, fetch_entry_t {pc, inst, branch_predict, branch_target}, fetch_state_t {IDLE, DATA, DROP}.
- Sub-module fetch_queue (parameterised QDEPTH of fetch_entry_t, push/pop/flush, count/full/empty).
- fetch_unit keeps the FSM, PC and tag registers.

Test Plan:
1. Reset release, zero-wait bus returning 0x00000013, f2d_ready=1 -> haddr 0x0,0x4,0x8…; f2d_pc=0x0 with inst 0x00000013 at cycle 2; thereafter one instruction per cycle.
2. f2d_ready=0 for 6 cycles -> exactly QDEPTH=2 entries queued; htrans drops to 0; no pushes lost; order 0x0,0x4 on release.
3. bp_taken=1, bp_target=0x100 when bp_pc=0x8 -> next haddr 0x100; entry 0x8 has branch_predict=1, branch_target=0x100.
4. redirect_valid, redirect_pc=0x200 while a data phase is pending and the queue holds 2 -> queue empty next cycle; the pending data is dropped; next haddr 0x200; first f2d_pc after is 0x200.
5. hready low 3 cycles during address and data phases -> haddr stable; no duplicate or missing entries; PC sequence intact.
6. Assert rst during DATA state -> all outputs at reset values asynchronously; fetch resumes at RESET_PC.
